prog_sequencer: RTL and testbench
=================================

# prog_sequencer

Run-control sequencer for the 9-bit single-issue core. It sits between the testbench Start/Ack handshake, the instruction decoder's opcode flags and the fetch unit. It gates PC advance, register-file and data-memory write enables per instruction, inserts wait cycles for loads, and halts on STOP. Cycle and retired-instruction counters are exposed for performance reporting.

## Interface
Parameters:
- CNT_W, 16: width of CycleCnt and InstrCnt
- LOAD_LAT, 1: extra wait cycles for load data return; legal range 0..7

Ports:
- Clk  in  1  system clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  level request from bench: program load/restart
- StopDec  in  1  decoder: current instruction is STOP
- LoadDec  in  1  decoder: current instruction is LDR
- StoreDec  in  1  decoder: current instruction is STRm
- RegWrDec  in  1  decoder: instruction writes the register file
- BranchDec  in  1  decoder: Badd/Bsub
- BranchCond  in  1  ALU flag condition satisfied
- PCInit  out  1  force PC to 0
- PCEn  out  1  PC update enable, either +1 or branch
- BranchTake  out  1  PC loads branch target this cycle
- RegWrEn  out  1  gated register-file write
- MemWrEn  out  1  gated data-memory write
- Done  out  1  Ack to bench: program halted
- CycleCnt  out  CNT_W  cycles spent in RUN+LWAIT
- InstrCnt  out  CNT_W  retired instructions, STOP excluded

## Operation
- FSM states: IDLE, ARM, RUN, LWAIT, DONE.
- IDLE: all outputs 0. Start=1 → ARM.
- ARM: PCInit=1. Both counters clear to 0. Stay in ARM while Start=1. Start=0 → RUN, so execution begins after Start falls.
- RUN, with one decoded instruction per cycle:
  - Start=1 → ARM (abort/restart); all write enables 0 that cycle.
  - Else StopDec=1 → DONE; PCEn, RegWrEn, MemWrEn, BranchTake all 0.
  - Else LoadDec=1 and LOAD_LAT>0 → LWAIT, wait counter loaded with LOAD_LAT-1; PCEn=0, RegWrEn=0.
  - Else PCEn=1, RegWrEn=RegWrDec, MemWrEn=StoreDec, BranchTake=BranchDec&BranchCond. When LOAD_LAT=0, a load retires in a single cycle with RegWrEn=RegWrDec.
- LWAIT: PCEn=0, write enables 0 until the wait counter reaches 0. In that final cycle RegWrEn=1 and PCEn=1, and the state returns to RUN. Start=1 → ARM, which takes priority over completion.
- DONE: Done=1 and all other outputs 0; counters hold. Start=1 → ARM.
- Gated outputs (RegWrEn, MemWrEn, PCEn, BranchTake) are 0 in every state other than RUN and LWAIT.
- BranchTake=1 implies PCEn=1.
- CycleCnt increments by 1 in every RUN and LWAIT cycle, including the STOP cycle. It saturates at 2^CNT_W-1.
- InstrCnt increments by 1 on every cycle with PCEn=1 and also saturates.
- Decoder inputs are sampled only in RUN. In LWAIT they are ignored, because the PC is held and they remain stable.

## Timing
- Reset low, at any time including mid-program: state goes to IDLE immediately and asynchronously, all outputs are 0, and counters and the wait counter are 0.
- State, counters and wait counter are registered.
- Output enables are combinational from state and the current decoder inputs.
- Start→execution: Start falls at edge N (ARM→RUN). The first instruction is at PC=0 in the cycle after edge N, and its writes commit at edge N+1.
- Non-load instruction: 1 cycle. Load instruction: 1+LOAD_LAT cycles.
- STOP is decoded in cycle k, and Done=1 from the edge ending cycle k. Done remains 1 until Start or Reset.
- Start held high across several cycles: the block stays in ARM with PCInit=1 and no execution occurs.
- Counter saturation: no wrap to 0 and no effect on the FSM.

## Test plan
- Reset mid-LWAIT with LOAD_LAT=3 → outputs 0 asynchronously; after release the block is in IDLE and CycleCnt=0.
- Start high 3 cycles then low, followed by 5 RegWrDec ops and STOP → 5 RegWrEn pulses, InstrCnt=5, CycleCnt=6, Done=1 on the cycle after STOP.
- LOAD_LAT=2, one LDR → PCEn=0 for 2 cycles, then a single cycle with RegWrEn=1 and PCEn=1; InstrCnt +1, CycleCnt +3.
- BranchDec=1: with BranchCond=1 → BranchTake=1 and PCEn=1; with BranchCond=0 → BranchTake=0 and PCEn=1; RegWrEn and MemWrEn both 0 in both cases.
- STRm with RegWrDec=0 → MemWrEn=1 for exactly 1 cycle. In IDLE/ARM/DONE with StoreDec=1 forced → MemWrEn=0.
- CNT_W=4 with 20 non-load instructions → CycleCnt and InstrCnt saturate at 15. Start pulse in DONE → counters clear, PCInit=1, and the program reruns.

Source files
------------

// File: rtl/prog_sequencer.sv
// Run-control sequencer for the 9-bit core: gates PC advance and write enables,
// stretches loads by LOAD_LAT wait cycles, halts on STOP and keeps perf counters.
module prog_sequencer #(
   parameter int CNT_W    = 16,
   parameter int LOAD_LAT = 1
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             StopDec,
   input  logic             LoadDec,
   input  logic             StoreDec,
   input  logic             RegWrDec,
   input  logic             BranchDec,
   input  logic             BranchCond,
   output logic             PCInit,
   output logic             PCEn,
   output logic             BranchTake,
   output logic             RegWrEn,
   output logic             MemWrEn,
   output logic             Done,
   output logic [CNT_W-1:0] CycleCnt,
   output logic [CNT_W-1:0] InstrCnt
);

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      RUN,
      LWAIT,
      DONE
   } state_t;

   localparam bit               HAS_LAT   = (LOAD_LAT > 0);
   localparam logic [2:0]       WAIT_INIT = HAS_LAT ? 3'(LOAD_LAT - 1) : 3'd0;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t           state_q, state_d;
   logic [2:0]       wait_q, wait_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] ins_q, ins_d;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         wait_q  <= 3'd0;
         cyc_q   <= '0;
         ins_q   <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         cyc_q   <= cyc_d;
         ins_q   <= ins_d;
      end
   end

   // Start always wins in RUN/LWAIT so a restart can never commit a write.
   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      PCInit     = 1'b0;
      PCEn       = 1'b0;
      BranchTake = 1'b0;
      RegWrEn    = 1'b0;
      MemWrEn    = 1'b0;
      Done       = 1'b0;
      case (state_q)
         IDLE: begin
            if (Start) state_d = ARM;
         end
         ARM: begin
            PCInit = 1'b1;
            if (!Start) state_d = RUN;
         end
         RUN: begin
            if (Start) begin
               state_d = ARM;
            end else if (StopDec) begin
               state_d = DONE;
            end else if (LoadDec && HAS_LAT) begin
               state_d = LWAIT;
               wait_d  = WAIT_INIT;
            end else begin
               PCEn       = 1'b1;
               RegWrEn    = RegWrDec;
               MemWrEn    = StoreDec;
               BranchTake = BranchDec & BranchCond;
            end
         end
         LWAIT: begin
            if (Start) begin
               state_d = ARM;
            end else if (wait_q == 3'd0) begin
               RegWrEn = 1'b1;
               PCEn    = 1'b1;
               state_d = RUN;
            end else begin
               wait_d = wait_q - 3'd1;
            end
         end
         DONE: begin
            Done = 1'b1;
            if (Start) state_d = ARM;
         end
         default: state_d = IDLE;
      endcase
   end

   // Counters clear while armed and saturate rather than wrap.
   always_comb begin
      cyc_d = cyc_q;
      ins_d = ins_q;
      if (state_q == ARM) begin
         cyc_d = '0;
         ins_d = '0;
      end else begin
         if ((state_q == RUN || state_q == LWAIT) && cyc_q != CNT_MAX) cyc_d = cyc_q + 1'b1;
         if (PCEn && ins_q != CNT_MAX) ins_d = ins_q + 1'b1;
      end
   end

   assign CycleCnt = cyc_q;
   assign InstrCnt = ins_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: program-level reference model pushes the
// expected per-cycle response, an independent monitor pops and compares it.
module tb_prog_sequencer;

   localparam int CNT_W    = 4;
   localparam int LOAD_LAT = 2;
   localparam int SAT      = (1 << CNT_W) - 1;

   localparam logic [5:0] F_INIT = 6'b100000;
   localparam logic [5:0] F_PCEN = 6'b010000;
   localparam logic [5:0] F_BT   = 6'b001000;
   localparam logic [5:0] F_RW   = 6'b000100;
   localparam logic [5:0] F_MW   = 6'b000010;
   localparam logic [5:0] F_DONE = 6'b000001;

   logic Clk = 1'b0;
   logic Reset = 1'b0;
   logic Start = 1'b0;
   logic StopDec = 1'b0, LoadDec = 1'b0, StoreDec = 1'b0;
   logic RegWrDec = 1'b0, BranchDec = 1'b0, BranchCond = 1'b0;
   logic PCInit, PCEn, BranchTake, RegWrEn, MemWrEn, Done;
   logic [CNT_W-1:0] CycleCnt, InstrCnt;

   prog_sequencer #(.CNT_W(CNT_W), .LOAD_LAT(LOAD_LAT)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start),
      .StopDec(StopDec), .LoadDec(LoadDec), .StoreDec(StoreDec),
      .RegWrDec(RegWrDec), .BranchDec(BranchDec), .BranchCond(BranchCond),
      .PCInit(PCInit), .PCEn(PCEn), .BranchTake(BranchTake),
      .RegWrEn(RegWrEn), .MemWrEn(MemWrEn), .Done(Done),
      .CycleCnt(CycleCnt), .InstrCnt(InstrCnt)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [5:0] flags;
      bit         chk;
      int         cyc;
      int         ins;
      int         tag;
   } exp_t;

   exp_t sb[$];
   int nVec = 0;
   int nBad = 0;

   // Program-level model: counter values and where the sequencer is parked
   // (0 idle, 1 halted, 2 armed after abort, 3 running).
   int mCyc = 0;
   int mIns = 0;
   int mPhase = 0;
   int armCycles = 0;

   function automatic logic [5:0] rnd6();
      return 6'($urandom);
   endfunction

   function automatic void incCyc();
      if (mCyc < SAT) mCyc++;
   endfunction

   function automatic void incIns();
      if (mIns < SAT) mIns++;
   endfunction

   task automatic pushExp(input logic [5:0] expF, input bit chk, input int tag);
      exp_t e;
      e.flags = expF;
      e.chk   = chk;
      e.cyc   = mCyc;
      e.ins   = mIns;
      e.tag   = tag;
      sb.push_back(e);
   endtask

   // dec = {StopDec, LoadDec, StoreDec, RegWrDec, BranchDec, BranchCond}
   task automatic applyStimulus(input logic st, input logic [5:0] dec,
                                input logic [5:0] expF, input bit chk, input int tag);
      @(posedge Clk);
      #1;
      Start = st;
      {StopDec, LoadDec, StoreDec, RegWrDec, BranchDec, BranchCond} = dec;
      pushExp(expF, chk, tag);
   endtask

   task automatic checkOutput(input exp_t e);
      logic [5:0] got;
      got = {PCInit, PCEn, BranchTake, RegWrEn, MemWrEn, Done};
      nVec++;
      if (got !== e.flags) begin
         nBad++;
         $display("FAIL flags tag=%0d t=%0t: got %b expected %b", e.tag, $time, got, e.flags);
      end
      if (e.chk) begin
         nVec++;
         if (int'(CycleCnt) != e.cyc || int'(InstrCnt) != e.ins) begin
            nBad++;
            $display("FAIL counters tag=%0d t=%0t: got cyc=%0d ins=%0d expected cyc=%0d ins=%0d",
                     e.tag, $time, CycleCnt, InstrCnt, e.cyc, e.ins);
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge Clk);
         if (sb.size() > 0) checkOutput(sb.pop_front());
      end
   end

   task automatic resetHold(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge Clk);
         #1;
         Reset = 1'b0;
         Start = 1'($urandom);
         {StopDec, LoadDec, StoreDec, RegWrDec, BranchDec, BranchCond} = rnd6();
         mCyc = 0; mIns = 0; mPhase = 0;
         pushExp(6'b0, 1'b1, 1);
      end
   endtask

   task automatic releaseReset();
      @(posedge Clk);
      #1;
      Reset = 1'b1;
      Start = 1'b0;
      pushExp(6'b0, 1'b1, 1);
   endtask

   task automatic resetMid();
      @(posedge Clk);
      #2;
      Reset = 1'b0;
      mCyc = 0; mIns = 0; mPhase = 0;
      pushExp(6'b0, 1'b1, 8);
   endtask

   task automatic startProgram(input int hold);
      bit armed;
      armed = (mPhase == 2);
      for (int i = 0; i < hold; i++) begin
         if (!armed) begin
            applyStimulus(1'b1, rnd6(), (mPhase == 1) ? F_DONE : 6'b0, 1'b1, 2);
            armed = 1'b1;
            armCycles = 0;
         end else begin
            applyStimulus(1'b1, rnd6(), F_INIT, armCycles > 0, 2);
            mCyc = 0; mIns = 0;
            armCycles++;
         end
      end
      applyStimulus(1'b0, rnd6(), F_INIT, armCycles > 0, 2);
      mCyc = 0; mIns = 0;
      mPhase = 3;
   endtask

   task automatic runAlu(input logic rw, input logic st, input logic br, input logic cond);
      logic [5:0] expF;
      expF = F_PCEN | (rw ? F_RW : 6'b0) | (st ? F_MW : 6'b0) | ((br && cond) ? F_BT : 6'b0);
      applyStimulus(1'b0, {2'b00, st, rw, br, cond}, expF, 1'b1, 3);
      incCyc();
      incIns();
   endtask

   task automatic runStop();
      applyStimulus(1'b0, {1'b1, 5'($urandom)}, 6'b0, 1'b1, 4);
      incCyc();
      mPhase = 1;
   endtask

   task automatic runAbort();
      applyStimulus(1'b1, rnd6(), 6'b0, 1'b1, 6);
      mPhase = 2;
      armCycles = 0;
   endtask

   // A load occupies 1+LOAD_LAT cycles; abortAt selects a cycle to raise Start in.
   task automatic runLoad(input int abortAt);
      logic [5:0] dec;
      for (int c = 0; c <= LOAD_LAT; c++) begin
         if (c == abortAt) begin
            runAbort();
            return;
         end
         dec = (c == 0) ? {4'b0101, 1'b0, 1'($urandom)} : rnd6();
         applyStimulus(1'b0, dec, (c == LOAD_LAT) ? (F_PCEN | F_RW) : 6'b0, 1'b1, 5);
         incCyc();
         if (c == LOAD_LAT) incIns();
      end
   endtask

   task automatic doneIdle(input int n);
      for (int i = 0; i < n; i++)
         applyStimulus(1'b0, rnd6() | 6'b001000, (mPhase == 1) ? F_DONE : 6'b0, 1'b1, 7);
   endtask

   initial begin
      #1_000_000;
      nBad++;
      $display("FAIL watchdog: simulation time limit reached, queue depth %0d expected 0", sb.size());
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
      $finish;
   end

   initial begin
      int len;
      int r;
      resetHold(2);
      releaseReset();

      startProgram(3);
      for (int i = 0; i < 5; i++) runAlu(1'b1, 1'b0, 1'b0, 1'b0);
      runStop();
      doneIdle(2);

      startProgram(1);
      runLoad(-1);
      runStop();
      doneIdle(1);

      startProgram(2);
      runAlu(1'b0, 1'b0, 1'b1, 1'b1);
      runAlu(1'b0, 1'b0, 1'b1, 1'b0);
      runAlu(1'b0, 1'b1, 1'b0, 1'b0);
      runStop();
      doneIdle(3);

      startProgram(1);
      for (int i = 0; i < 20; i++) runAlu(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      runStop();
      doneIdle(2);
      startProgram(1);
      runAlu(1'b1, 1'b0, 1'b0, 1'b0);
      runStop();
      doneIdle(1);

      startProgram(1);
      runAlu(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 6'b010100, 6'b0, 1'b1, 5);
      incCyc();
      applyStimulus(1'b0, 6'b010100, 6'b0, 1'b1, 5);
      incCyc();
      resetMid();
      resetHold(1);
      releaseReset();

      for (int p = 0; p < 40; p++) begin
         startProgram($urandom_range(1, 3));
         len = $urandom_range(1, 10);
         for (int k = 0; k < len && mPhase == 3; k++) begin
            r = $urandom_range(0, 19);
            if (r == 0) runAbort();
            else if (r < 5) runLoad(($urandom_range(0, 7) == 0) ? $urandom_range(0, LOAD_LAT) : -1);
            else runAlu(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         end
         if (mPhase == 3) begin
            runStop();
            doneIdle($urandom_range(0, 2));
         end
         if ($urandom_range(0, 9) == 0) begin
            resetHold(1);
            releaseReset();
         end
      end

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge Clk);
      @(posedge Clk);
      if (sb.size() != 0) begin
         nBad++;
         $display("FAIL drain: queue depth %0d expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
      $finish;
   end

endmodule
